// File: rtl/rah_pkg.sv
// RAH link framing constants, FSM encodings and frame-building helpers shared by the encoder and decoder.
// Header frame: cfg_sel | slv_id | length | 4 data bytes; continuation frames carry 6 data bytes.
package rah_pkg;

  localparam int RAH_PACKET_WIDTH = 48;

  localparam int CFG_BIT      = 47;
  localparam int SLV_ID_MSB   = 46;
  localparam int SLV_ID_LSB   = 40;
  localparam int LEN_MSB      = 39;
  localparam int LEN_LSB      = 32;
  localparam int HDR_DATA_MSB = 31;

  localparam int HDR_DATA_BYTES  = 4;
  localparam int CONT_DATA_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } rah_state_t;

  typedef logic [RAH_PACKET_WIDTH-1:0] rah_frame_t;

  function automatic rah_frame_t rah_header(input logic       cfg_sel,
                                            input logic [6:0] slv_id,
                                            input logic [7:0] length);
    rah_frame_t f;
    f                        = '0;
    f[CFG_BIT]               = cfg_sel;
    f[SLV_ID_MSB:SLV_ID_LSB] = slv_id;
    f[LEN_MSB:LEN_LSB]       = length;
    return f;
  endfunction

  // Header frames fill from bit 31 downward, continuation frames from bit 47 downward.
  function automatic rah_frame_t rah_put_byte(input rah_frame_t f,
                                              input logic       hdr,
                                              input logic [2:0] slot,
                                              input logic [7:0] b);
    rah_frame_t r;
    r = f;
    for (int i = 0; i < CONT_DATA_BYTES; i++) begin
      if (slot == 3'(i)) begin
        if (!hdr) begin
          r[RAH_PACKET_WIDTH-1-8*i -: 8] = b;
        end else if (i < HDR_DATA_BYTES) begin
          r[HDR_DATA_MSB-8*i -: 8] = b;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] rah_slot_cap(input logic hdr);
    return hdr ? 3'(HDR_DATA_BYTES) : 3'(CONT_DATA_BYTES);
  endfunction

  function automatic int rah_frame_count(input logic [7:0] length);
    int len;
    len = int'(length);
    if (len <= HDR_DATA_BYTES) return 1;
    return 1 + (len - HDR_DATA_BYTES + CONT_DATA_BYTES - 1) / CONT_DATA_BYTES;
  endfunction

endpackage

// File: rtl/apb_encoder.sv
// RAH transmit framer: packs a request header plus byte stream into 48-bit frames; wr_en lands 2 cycles after a frame's last byte.
// Backpressure: f_full holds the FSM in PUSH with byte_ready low; the frame is kept intact until the FIFO has room.
module apb_encoder
  import rah_pkg::*;
#(
  parameter int RAH_PACKET_WIDTH = rah_pkg::RAH_PACKET_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_start,
  input  logic                        tx_cfg_sel,
  input  logic [6:0]                  tx_slv_id,
  input  logic [7:0]                  tx_length,
  output logic                        tx_busy,
  output logic                        tx_done,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  input  logic                        f_full,
  output logic                        wr_en,
  output logic [RAH_PACKET_WIDTH-1:0] f_data
);

  rah_state_t state, state_nxt;
  rah_frame_t frame;
  logic [7:0] rem;
  logic [2:0] slot;
  logic [2:0] cap;
  logic       hdr;
  logic       xfer;
  logic       accept;

  // The wr_en/tx_done cycle is already IDLE but still counts as busy.
  assign tx_busy = (state != IDLE) || tx_done;
  assign accept  = (state == IDLE) && tx_start && !tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    xfer       = 1'b0;
    cap        = rah_slot_cap(hdr);
    case (state)
      IDLE: begin
        if (accept) state_nxt = COLLECT;
      end
      COLLECT: begin
        byte_ready = (rem != 8'd0) && (slot < cap);
        xfer       = byte_valid && byte_ready;
        if (rem == 8'd0) begin
          state_nxt = PUSH;
        end else if (xfer && ((slot + 3'd1 == cap) || (rem == 8'd1))) begin
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        if (!f_full) state_nxt = (rem == 8'd0) ? IDLE : COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame   <= '0;
      rem     <= 8'd0;
      slot    <= 3'd0;
      hdr     <= 1'b0;
      wr_en   <= 1'b0;
      tx_done <= 1'b0;
      f_data  <= '0;
    end else begin
      wr_en   <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            frame <= rah_header(tx_cfg_sel, tx_slv_id, tx_length);
            rem   <= tx_length;
            slot  <= 3'd0;
            hdr   <= 1'b1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            frame <= rah_put_byte(frame, hdr, slot, byte_data);
            slot  <= slot + 3'd1;
            rem   <= rem - 8'd1;
          end
        end
        PUSH: begin
          if (!f_full) begin
            f_data  <= frame;
            wr_en   <= 1'b1;
            tx_done <= (rem == 8'd0);
            if (rem != 8'd0) begin
              frame <= '0;
              hdr   <= 1'b0;
              slot  <= 3'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_encoder.sv
// Directed bench for apb_encoder: byte source, FIFO-full stimulus and write capture run alongside the scenario sequence.
module tb_apb_encoder;

  logic        clk;
  logic        rst;
  logic        tx_start;
  logic        tx_cfg_sel;
  logic [6:0]  tx_slv_id;
  logic [7:0]  tx_length;
  logic        tx_busy;
  logic        tx_done;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        f_full;
  logic        wr_en;
  logic [47:0] f_data;

  apb_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_cfg_sel (tx_cfg_sel),
    .tx_slv_id  (tx_slv_id),
    .tx_length  (tx_length),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .f_full     (f_full),
    .wr_en      (wr_en),
    .f_data     (f_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scenario settings, owned by the main sequence.
  int         pkt_id = 0;
  int         pkt_len = 0;
  logic       hold_mode = 1'b0;
  logic [7:0] byte_mem [0:255];
  int         start_cyc = 0;

  // Observation state, owned by the monitor.
  int          cyc;
  int          mon_pkt;
  int          xfer_total;
  int          n_wr;
  int          done_cnt;
  int          rdy_cnt;
  int          rdy_bad;
  int          full_wr_bad;
  int          hold_cnt;
  logic        xfer_pend;
  logic        full_prev;
  logic [47:0] wr_dat  [0:63];
  logic        wr_done [0:63];
  int          wr_cyc  [0:63];

  function automatic int n_frames(input int len);
    return (len <= 4) ? 1 : 1 + (len - 4 + 5) / 6;
  endfunction

  function automatic int frame_end(input int len, input int w);
    int e;
    e = 4 + 6 * w;
    return (e < len) ? e : len;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic waiting;
    mon_pkt = 0; xfer_total = 0; n_wr = 0; done_cnt = 0; rdy_cnt = 0;
    rdy_bad = 0; full_wr_bad = 0; hold_cnt = 0;
    xfer_pend = 1'b0; full_prev = 1'b0;
    f_full = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    forever begin
      @(negedge clk);
      if (pkt_id != mon_pkt) begin
        mon_pkt = pkt_id; xfer_total = 0; n_wr = 0; done_cnt = 0;
        rdy_cnt = 0; hold_cnt = 0; xfer_pend = 1'b0;
      end else if (xfer_pend) begin
        xfer_total++;
      end
      if (wr_en) begin
        if (n_wr < 64) begin
          wr_dat[n_wr]  = f_data;
          wr_done[n_wr] = tx_done;
          wr_cyc[n_wr]  = cyc;
        end
        n_wr++;
        if (full_prev) full_wr_bad++;
      end
      if (tx_done) done_cnt++;
      if (byte_ready) rdy_cnt++;
      // A frame is complete but not yet written: the encoder must be in PUSH.
      waiting = tx_busy && (n_wr < n_frames(pkt_len)) && (xfer_total == frame_end(pkt_len, n_wr));
      if (waiting && byte_ready) rdy_bad++;
      if (hold_mode && waiting && hold_cnt < 5) begin
        f_full = 1'b1;
        hold_cnt++;
      end else begin
        f_full = 1'b0;
        if (!waiting) hold_cnt = 0;
      end
      byte_valid = (xfer_total < pkt_len);
      byte_data  = (xfer_total < 256) ? byte_mem[xfer_total] : 8'h00;
      xfer_pend  = byte_valid && byte_ready;
      full_prev  = f_full;
    end
  end

  task automatic send(input logic cfg, input logic [6:0] id, input int len,
                      input logic hold, input logic pulses);
    @(negedge clk);
    hold_mode  = hold;
    pkt_len    = len;
    pkt_id++;
    tx_cfg_sel = cfg;
    tx_slv_id  = id;
    tx_length  = 8'(len);
    tx_start   = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
      if (pulses && (i == 3 || i == 10 || i == 16)) begin
        tx_start = 1'b1; tx_length = 8'd3; tx_slv_id = 7'h55; tx_cfg_sel = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
    end
    tx_start = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("busy_at_done", tx_busy, 1'b1);
    @(negedge clk);
    #1;
    chk("idle_after_done", tx_busy, 1'b0);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_f_data"}, f_data, 48'h0);
    chk({tag, "_busy"}, tx_busy, 1'b0);
    chk({tag, "_done"}, tx_done, 1'b0);
    chk({tag, "_ready"}, byte_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_cfg_sel = 1'b0; tx_slv_id = 7'h00; tx_length = 8'h00;
    for (int i = 0; i < 256; i++) byte_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two-byte single frame.
    byte_mem[0] = 8'hAA; byte_mem[1] = 8'hBB;
    send(1'b1, 7'h05, 2, 1'b0, 1'b0);
    chk("s1_writes", n_wr, 1);
    chk("s1_frame0", wr_dat[0], 48'h8502AABB0000);
    chk("s1_done0", wr_done[0], 1'b1);
    chk("s1_latency", wr_cyc[0] - start_cyc, 4);

    // Header plus one full continuation frame.
    for (int i = 0; i < 10; i++) byte_mem[i] = 8'(i + 1);
    send(1'b0, 7'h12, 10, 1'b0, 1'b0);
    chk("s2_writes", n_wr, 2);
    chk("s2_frame0", wr_dat[0], 48'h120A01020304);
    chk("s2_done0", wr_done[0], 1'b0);
    chk("s2_frame1", wr_dat[1], 48'h05060708090A);
    chk("s2_done1", wr_done[1], 1'b1);

    // Partial continuation frame is zero padded.
    for (int i = 0; i < 7; i++) byte_mem[i] = 8'(8'h11 * (i + 1));
    send(1'b0, 7'h01, 7, 1'b0, 1'b0);
    chk("s3_writes", n_wr, 2);
    chk("s3_frame0", wr_dat[0], 48'h010711223344);
    chk("s3_frame1", wr_dat[1], 48'h556677000000);

    // Zero-length packet.
    send(1'b1, 7'h7F, 0, 1'b0, 1'b0);
    chk("s4_writes", n_wr, 1);
    chk("s4_frame0", wr_dat[0], 48'hFF0000000000);
    chk("s4_latency", wr_cyc[0] - start_cyc, 3);
    chk("s4_no_ready", rdy_cnt, 0);
    chk("s4_done0", wr_done[0], 1'b1);

    // FIFO full for 5 cycles at each PUSH, stray tx_start pulses while busy.
    for (int i = 0; i < 10; i++) byte_mem[i] = 8'(i + 1);
    send(1'b0, 7'h12, 10, 1'b1, 1'b1);
    chk("s5_writes", n_wr, 2);
    chk("s5_frame0", wr_dat[0], 48'h120A01020304);
    chk("s5_frame1", wr_dat[1], 48'h05060708090A);
    chk("s5_done1", wr_done[1], 1'b1);
    chk("s5_gap", wr_cyc[1] - wr_cyc[0], 12);
    chk("s5_wr_while_full", full_wr_bad, 0);
    chk("s5_ready_in_push", rdy_bad, 0);

    // Reset after 6 of 10 bytes.
    @(negedge clk);
    hold_mode = 1'b0; pkt_len = 10; pkt_id++;
    tx_cfg_sel = 1'b0; tx_slv_id = 7'h12; tx_length = 8'd10; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 100 && xfer_total < 6; i++) begin
      @(negedge clk);
      #1;
    end
    chk("s6_bytes_before_rst", xfer_total, 6);
    chk("s6_writes_before_rst", n_wr, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("s6_in_reset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("s6_no_write_after_rst", n_wr, 1);
    check_reset_outputs("s6_after_rst");

    // Fresh request after the abandoned packet.
    byte_mem[0] = 8'hC1; byte_mem[1] = 8'hC2;
    send(1'b0, 7'h33, 2, 1'b0, 1'b0);
    chk("s7_writes", n_wr, 1);
    chk("s7_frame0", wr_dat[0], 48'h3302C1C20000);
    chk("s7_done0", wr_done[0], 1'b1);

    chk("ready_in_push_total", rdy_bad, 0);
    chk("wr_while_full_total", full_wr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_encoder.md
Name: apb_encoder

Overview:
- Transmit-side framer for the RAH packet link, the counterpart of the RAH packet decoder.
- Takes a request descriptor (cfg_sel, slave ID, byte length) and a byte stream, typically APB read-response data.
- Packs them into 48-bit RAH frames and writes the frames into the outgoing TX FIFO.
- Frame layout:
  - Header frame: [47] cfg_sel, [46:40] slv_id, [39:32] length, [31:0] first up to 4 data bytes.
  - Continuation frames: 6 data bytes each.

Parameters:
- RAH_PACKET_WIDTH, 48, FIFO word width. The frame layout requires 48; any other value is unsupported.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tx_start  input  1  request strobe; accepted only when tx_busy=0
- tx_cfg_sel  input  1  config-select bit, sampled with tx_start
- tx_slv_id  input  7  slave ID, sampled with tx_start
- tx_length  input  8  payload byte count 0..255, sampled with tx_start
- tx_busy  output  1  high from the cycle after accept until the cycle after tx_done
- tx_done  output  1  one-cycle pulse, coincident with the final wr_en
- byte_valid  input  1  payload byte valid
- byte_data  input  8  payload byte
- byte_ready  output  1  encoder can take a byte; transfer occurs when valid&ready
- f_full  input  1  TX FIFO full
- wr_en  output  1  FIFO write strobe, one cycle per frame
- f_data  output  48  frame data; meaningful only while wr_en=1

Behaviour:
- Reset values: wr_en=0, f_data=0, tx_busy=0, tx_done=0, byte_ready=0, state=IDLE, all counters 0. Reset mid-packet abandons the partial frame. No FIFO write occurs in the reset cycle or after it.
- IDLE
  - tx_start=1 latches cfg_sel, slv_id and length. rem=length, slot=0, hdr=1.
  - Builds header bits [47:32] and moves to COLLECT.
  - tx_start while busy is ignored and has no effect.
- COLLECT
  - cap = 4 if hdr, else 6.
  - byte_ready=1 when rem>0 and slot<cap.
  - On transfer, the byte is written to:
    - [31-8*slot -: 8] if hdr;
    - [47-8*slot -: 8] otherwise.
  - Then slot++ and rem--.
  - Goes to PUSH when slot==cap or rem==0. This includes entry with length 0, which moves to PUSH the next cycle with the header data field zero.
  - Unfilled byte positions are 0.
- PUSH
  - byte_ready=0.
  - While f_full=1: hold; the frame is unchanged.
  - When f_full=0: register f_data<=frame and wr_en<=1 for exactly one cycle. Then:
    - if rem==0: assert tx_done with that wr_en and return to IDLE;
    - else clear the frame, set hdr=0 and slot=0, and return to COLLECT.
- Frame count is 1 for length<=4, else 1+ceil((length-4)/6). Maximum 43 frames at length 255.
- rem is 8-bit and never underflows, because byte_ready is gated by rem>0.
- Latency:
  - Length 0 with FIFO not full: tx_start at cycle 0, COLLECT at 1, PUSH at 2, wr_en and tx_done at 3.
  - General case: wr_en appears 2 cycles after the cycle the last byte of a frame transfers, given f_full=0.
- tx_busy=1 in COLLECT and PUSH and during the wr_en cycle. tx_busy=0 in IDLE thereafter.
- A new tx_start is accepted in the first IDLE cycle after tx_done.

Decomposition:
- Shared package rah_pkg holds:
  - RAH_PACKET_WIDTH;
  - field positions CFG_BIT=47, SLV_ID_MSB/LSB=46/40, LEN_MSB/LSB=39/32;
  - HDR_DATA_BYTES=4 and CONT_DATA_BYTES=6;
  - FSM state encodings IDLE/COLLECT/PUSH.
- The package is shared with the decoder.
- No sub-module. The byte-slot packer is small enough to remain inline.

Test Plan:
- cfg_sel=1, slv_id=7'h05, length=2, bytes AA,BB, f_full=0 -> single wr_en, f_data=48'h8502AABB0000, tx_done with it.
- cfg_sel=0, slv_id=7'h12, length=10, bytes 01..0A -> f_data=48'h120A01020304, then 48'h05060708090A; tx_done on the second write; exactly 2 writes.
- cfg_sel=0, slv_id=7'h01, length=7, bytes 11..77 -> 48'h010711223344, then 48'h556677000000 (zero padding).
- length=0, slv_id=7'h7F, cfg_sel=1 -> one write 48'hFF0000000000 at cycle 3 after tx_start; no byte_ready assertion.
- length=10 with f_full held high 5 cycles at each PUSH -> no wr_en and byte_ready=0 while full; frames identical to scenario 2; extra tx_start pulses during busy are ignored.
- Reset mid-packet:
  - length=10, assert rst after 6 bytes -> no further wr_en; all outputs at reset values.
  - Then a new length=2 request -> correct single frame.
